// File: rtl/stream_src_pkg.sv
// Shared types and constants for the LFSR-driven valid/ready stream source.
package stream_src_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

    localparam int MODE_RANDOM = 0;
    localparam int MODE_INCR   = 1;

    // One Galois step for x^32+x^22+x^2+x+1 (right-shifting form).
    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
    endfunction

endpackage

// File: rtl/lfsr_stream_source_lfsr32.sv
// 32-bit Galois LFSR: steps when step_en is high, synchronous reload of the seed.
// Async reset to the seed; a zero seed is replaced by 1 so the register never locks up.
module lfsr32
    import stream_src_pkg::*;
#(
    parameter logic [31:0] SEED = 32'd1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        step_en,
    input  logic        load_en,
    output logic [31:0] state_dat
);

    localparam logic [31:0] SEED_EFF = (SEED == 32'd0) ? 32'd1 : SEED;

    logic [31:0] lfsr_q;
    logic [31:0] lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (load_en) begin
            lfsr_d = SEED_EFF;
        end else if (step_en) begin
            lfsr_d = lfsr_next(lfsr_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= SEED_EFF;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign state_dat = lfsr_q;

endmodule

// File: rtl/lfsr_stream_source.sv
// Valid/ready stimulus source with pseudo-random valid pattern and random or counting payload.
// All outputs registered; a presented item is held until accepted, optional item limit ends in DONE.
module lfsr_stream_source
    import stream_src_pkg::*;
#(
    parameter int          WIDTH   = 9,
    parameter logic [31:0] SEED    = 32'd100,
    parameter int          DENSITY = 8,
    parameter int          MODE    = 0,
    parameter int          N_ITEMS = 0,
    parameter int          CNT_W   = 16
) (
    input  logic             i_CLK,
    input  logic             i_RSTn,
    input  logic             i_EN,
    input  logic             i_READY,
    output logic             o_VALID,
    output logic [WIDTH-1:0] o_Y,
    output logic             o_LAST,
    output logic             o_DONE,
    output logic [CNT_W-1:0] o_CNT
);

    localparam bit               HAS_LIMIT = (N_ITEMS > 0);
    localparam logic [CNT_W-1:0] LAST_IDX  = HAS_LIMIT ? CNT_W'(N_ITEMS - 1) : '0;
    localparam logic [4:0]       DENS      = 5'(DENSITY);

    state_t             state_q, state_d;
    logic               vld_q, vld_d;
    logic [WIDTH-1:0]   y_q, y_d;
    logic               last_q, last_d;
    logic               done_q, done_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic [31:0]        lfsr_dat;
    logic               xfer;
    logic               launch_ok;
    logic [WIDTH-1:0]   y_rand;

    lfsr32 #(.SEED(SEED)) u_lfsr (
        .clk       (i_CLK),
        .rst_n     (i_RSTn),
        .step_en   (state_q == ACTIVE),
        .load_en   (1'b0),
        .state_dat (lfsr_dat)
    );

    assign xfer      = vld_q & i_READY;
    assign launch_ok = ({1'b0, lfsr_dat[3:0]} < DENS);
    // Random payload comes from the value the LFSR steps to on this same edge.
    assign y_rand    = WIDTH'(lfsr_next(lfsr_dat));

    always_comb begin
        state_d = state_q;
        vld_d   = vld_q;
        y_d     = y_q;
        done_d  = done_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        case (state_q)
            IDLE: begin
                vld_d = 1'b0;
                if (i_EN) begin
                    state_d = ACTIVE;
                end
            end
            ACTIVE: begin
                if (xfer) begin
                    cnt_d  = cnt_q + CNT_W'(1);
                    data_d = data_q + WIDTH'(1);
                end
                if (xfer && HAS_LIMIT && (cnt_q == LAST_IDX)) begin
                    state_d = DONE;
                    vld_d   = 1'b0;
                    done_d  = 1'b1;
                end else if (!vld_q || xfer) begin
                    if (i_EN && launch_ok) begin
                        vld_d = 1'b1;
                        y_d   = (MODE == MODE_INCR) ? data_d : y_rand;
                    end else begin
                        vld_d = 1'b0;
                    end
                    if (!i_EN) begin
                        state_d = IDLE;
                    end
                end
            end
            DONE: begin
                vld_d  = 1'b0;
                done_d = 1'b1;
            end
            default: begin
                state_d = IDLE;
                vld_d   = 1'b0;
            end
        endcase
        last_d = HAS_LIMIT && vld_d && (cnt_d == LAST_IDX);
    end

    always_ff @(posedge i_CLK or negedge i_RSTn) begin
        if (!i_RSTn) begin
            state_q <= IDLE;
            vld_q   <= 1'b0;
            y_q     <= '0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            vld_q   <= vld_d;
            y_q     <= y_d;
            last_q  <= last_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
        end
    end

    assign o_VALID = vld_q;
    assign o_Y     = y_q;
    assign o_LAST  = last_q;
    assign o_DONE  = done_q;
    assign o_CNT   = cnt_q;

endmodule

// File: tb/tb_lfsr_stream_source.sv
// Bench for lfsr_stream_source: five differently parameterised instances exercised in turn,
// payloads checked against a Galois LFSR reference and an item-level handshake model.
module tb_lfsr_stream_source;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    int   vectors = 0;
    int   miscompares = 0;

    logic en_inc, rdy_inc, vld_inc, last_inc, done_inc;
    logic [8:0]  y_inc;
    logic [15:0] cnt_inc;
    logic en_rnd, rdy_rnd, vld_rnd, last_rnd, done_rnd;
    logic [8:0]  y_rnd;
    logic [15:0] cnt_rnd;
    logic en_lim, rdy_lim, vld_lim, last_lim, done_lim;
    logic [8:0]  y_lim;
    logic [15:0] cnt_lim;
    logic en_d0, rdy_d0, vld_d0, last_d0, done_d0;
    logic [8:0]  y_d0;
    logic [15:0] cnt_d0;
    logic en_d8, rdy_d8, vld_d8, last_d8, done_d8;
    logic [8:0]  y_d8;
    logic [15:0] cnt_d8;

    lfsr_stream_source #(.WIDTH(9), .SEED(32'd100), .DENSITY(16), .MODE(1), .N_ITEMS(0), .CNT_W(16)) u_inc (
        .i_CLK(clk), .i_RSTn(rst_n), .i_EN(en_inc), .i_READY(rdy_inc), .o_VALID(vld_inc),
        .o_Y(y_inc), .o_LAST(last_inc), .o_DONE(done_inc), .o_CNT(cnt_inc));
    lfsr_stream_source #(.WIDTH(9), .SEED(32'd100), .DENSITY(16), .MODE(0), .N_ITEMS(0), .CNT_W(16)) u_rnd (
        .i_CLK(clk), .i_RSTn(rst_n), .i_EN(en_rnd), .i_READY(rdy_rnd), .o_VALID(vld_rnd),
        .o_Y(y_rnd), .o_LAST(last_rnd), .o_DONE(done_rnd), .o_CNT(cnt_rnd));
    lfsr_stream_source #(.WIDTH(9), .SEED(32'd100), .DENSITY(16), .MODE(1), .N_ITEMS(4), .CNT_W(16)) u_lim (
        .i_CLK(clk), .i_RSTn(rst_n), .i_EN(en_lim), .i_READY(rdy_lim), .o_VALID(vld_lim),
        .o_Y(y_lim), .o_LAST(last_lim), .o_DONE(done_lim), .o_CNT(cnt_lim));
    lfsr_stream_source #(.WIDTH(9), .SEED(32'd100), .DENSITY(0), .MODE(0), .N_ITEMS(0), .CNT_W(16)) u_d0 (
        .i_CLK(clk), .i_RSTn(rst_n), .i_EN(en_d0), .i_READY(rdy_d0), .o_VALID(vld_d0),
        .o_Y(y_d0), .o_LAST(last_d0), .o_DONE(done_d0), .o_CNT(cnt_d0));
    lfsr_stream_source #(.WIDTH(9), .SEED(32'd100), .DENSITY(8), .MODE(0), .N_ITEMS(0), .CNT_W(16)) u_d8 (
        .i_CLK(clk), .i_RSTn(rst_n), .i_EN(en_d8), .i_READY(rdy_d8), .o_VALID(vld_d8),
        .o_Y(y_d8), .o_LAST(last_d8), .o_DONE(done_d8), .o_CNT(cnt_d8));

    // Reference polynomial step x^32+x^22+x^2+x+1 in right-shifting Galois form.
    function automatic logic [31:0] gstep(input logic [31:0] s);
        logic [31:0] r;
        r = s >> 1;
        if (s[0]) r = r ^ 32'h8020_0003;
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag, input logic v, input logic [8:0] y,
                            input logic l, input logic d, input logic [15:0] c);
        chk({tag, "_vld"}, 32'(v), 32'd0);
        chk({tag, "_y"}, 32'(y), 32'd0);
        chk({tag, "_last"}, 32'(l), 32'd0);
        chk({tag, "_done"}, 32'(d), 32'd0);
        chk({tag, "_cnt"}, 32'(c), 32'd0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk_zero({tag, "_inc"}, vld_inc, y_inc, last_inc, done_inc, cnt_inc);
        chk_zero({tag, "_rnd"}, vld_rnd, y_rnd, last_rnd, done_rnd, cnt_rnd);
        chk_zero({tag, "_lim"}, vld_lim, y_lim, last_lim, done_lim, cnt_lim);
        chk_zero({tag, "_d0"}, vld_d0, y_d0, last_d0, done_d0, cnt_d0);
        chk_zero({tag, "_d8"}, vld_d8, y_d8, last_d8, done_d8, cnt_d8);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [8:0]  ref8 [8];
        logic [31:0] s;
        logic [31:0] m_s;
        logic        m_act, m_vld, xfer, en_c, rdy_c;
        logic [8:0]  m_y;
        logic [15:0] m_cnt;
        int          nv;

        s = 32'd100;
        for (int i = 0; i < 8; i++) begin
            s = gstep(s);
            ref8[i] = s[8:0];
        end

        en_inc = 0; rdy_inc = 0; en_rnd = 0; rdy_rnd = 0; en_lim = 0; rdy_lim = 0;
        en_d0 = 0; rdy_d0 = 0; en_d8 = 0; rdy_d8 = 0;

        // Reset, then idle with enable low.
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1 chk_all_zero("rst");
        step();
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            chk_all_zero("idle");
        end

        // Incrementing payload, full density, always ready.
        en_inc = 1; rdy_inc = 1;
        step();
        chk("inc_first_edge_vld", 32'(vld_inc), 32'd0);
        step();
        for (int j = 0; j <= 520; j++) begin
            chk("inc_vld", 32'(vld_inc), 32'd1);
            chk("inc_y", 32'(y_inc), 32'(j % 512));
            chk("inc_cnt", 32'(cnt_inc), 32'(j));
            chk("inc_last", 32'(last_inc), 32'd0);
            step();
        end
        en_inc = 0;

        // Random payload with a backpressure stall and enable dropped during the stall.
        m_s = 32'd100; m_act = 0; m_vld = 0; m_y = '0; m_cnt = '0;
        for (int c = 0; c < 60; c++) begin
            rdy_c = !(c >= 12 && c < 17) && ($urandom_range(0, 7) != 0 || c < 20);
            en_c  = !(c >= 13 && c < 16);
            en_rnd = en_c; rdy_rnd = rdy_c;
            step();
            if (!m_act) begin
                if (en_c) m_act = 1;
            end else begin
                xfer = m_vld && rdy_c;
                if (xfer) m_cnt = m_cnt + 16'd1;
                m_s = gstep(m_s);
                if (!m_vld || xfer) begin
                    if (en_c) begin
                        m_vld = 1;
                        m_y = m_s[8:0];
                    end else begin
                        m_vld = 0;
                        m_act = 0;
                    end
                end
            end
            chk("rnd_vld", 32'(vld_rnd), 32'(m_vld));
            if (m_vld) chk("rnd_y", 32'(y_rnd), 32'(m_y));
            chk("rnd_cnt", 32'(cnt_rnd), 32'(m_cnt));
        end
        en_rnd = 1; rdy_rnd = 1;

        // Item limit of four.
        en_lim = 1; rdy_lim = 1;
        step();
        chk("lim_first_edge_vld", 32'(vld_lim), 32'd0);
        step();
        for (int j = 0; j < 4; j++) begin
            chk("lim_vld", 32'(vld_lim), 32'd1);
            chk("lim_y", 32'(y_lim), 32'(j));
            chk("lim_last", 32'(last_lim), 32'(j == 3));
            chk("lim_cnt", 32'(cnt_lim), 32'(j));
            chk("lim_done_early", 32'(done_lim), 32'd0);
            step();
        end
        for (int k = 0; k < 10; k++) begin
            chk("lim_vld_after", 32'(vld_lim), 32'd0);
            chk("lim_done", 32'(done_lim), 32'd1);
            chk("lim_cnt_final", 32'(cnt_lim), 32'd4);
            chk("lim_last_after", 32'(last_lim), 32'd0);
            step();
        end

        // Density zero never launches.
        en_d0 = 1; rdy_d0 = 1;
        for (int i = 0; i < 1000; i++) begin
            step();
            chk("d0_vld", 32'(vld_d0), 32'd0);
        end
        chk("d0_cnt", 32'(cnt_d0), 32'd0);

        // Density eight gives roughly half duty.
        en_d8 = 1; rdy_d8 = 1;
        nv = 0;
        for (int i = 0; i < 10000; i++) begin
            step();
            if (vld_d8) nv++;
        end
        chk("d8_duty_in_40_60", 32'(nv >= 4000 && nv <= 6000), 32'd1);

        // Reset asserted in the middle of a stall, then replay from the seed.
        rdy_rnd = 0;
        step();
        step();
        chk("stall_vld_before_rst", 32'(vld_rnd), 32'd1);
        #2 rst_n = 1'b0;
        #1 chk_zero("rst_mid_stall", vld_rnd, y_rnd, last_rnd, done_rnd, cnt_rnd);
        step();
        step();
        rst_n = 1'b1; en_rnd = 1; rdy_rnd = 1;
        step();
        chk("replay_first_edge_vld", 32'(vld_rnd), 32'd0);
        step();
        for (int i = 0; i < 8; i++) begin
            chk("replay_vld", 32'(vld_rnd), 32'd1);
            chk("replay_y", 32'(y_rnd), 32'(ref8[i]));
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/lfsr_stream_source.md
# lfsr_stream_source

Parametrised, synthesizable valid/ready stimulus source for the ALU test environment. It produces a data stream with a pseudo-random valid pattern. Payload is either pseudo-random or an incrementing count. The block obeys the full handshake contract: a presented item stays stable until it is accepted. It sits between the clock/reset generator and the DUT input port. An optional item count lets a bench end a run deterministically with a last-item flag and a done flag.

## Interface
- WIDTH, 9: payload width, legal range 1..32.
- SEED, 32'd100: LFSR reset value; 0 is illegal and is replaced by 1.
- DENSITY, 8: valid launch threshold, range 0..16; a launch needs lfsr[3:0] < DENSITY.
- MODE, 0: payload source; 0 = random (LFSR bits), 1 = incrementing counter.
- N_ITEMS, 0: transfers before stopping; 0 = unlimited.
- CNT_W, 16: width of the transfer counter.

- i_CLK  in  1  clock, single domain, rising edge.
- i_RSTn  in  1  asynchronous active-low reset.
- i_EN  in  1  permission to launch new items.
- i_READY  in  1  downstream accepts the current item.
- o_VALID  out  1  item presented on o_Y.
- o_Y  out  WIDTH  payload.
- o_LAST  out  1  the current item is item N_ITEMS-1; only possible when N_ITEMS>0.
- o_DONE  out  1  N_ITEMS transfers have completed; sticky.
- o_CNT  out  CNT_W  number of accepted transfers; wraps modulo 2^CNT_W.

## Operation
- Reset (async assert, sync release): state=IDLE, lfsr=SEED (1 if SEED==0), data counter=0.
- Output reset values: o_VALID=0, o_Y=0, o_LAST=0, o_DONE=0, o_CNT=0.
- LFSR: 32-bit Galois, polynomial x^32+x^22+x^2+x+1, taps 32'h8020_0003.
  - It advances one step every cycle while in ACTIVE, independent of the handshake.
  - It is frozen in IDLE and DONE.
- Transfer: o_VALID & i_READY at a rising edge.
- States:
  - IDLE: o_VALID=0. i_EN=1 → ACTIVE.
  - ACTIVE, slot free (o_VALID=0 or a transfer this edge):
    - If i_EN=1 and lfsr[3:0] < DENSITY, load o_Y and set o_VALID=1. Otherwise clear o_VALID.
    - If i_EN=0 and there is no pending item → IDLE.
  - ACTIVE, stall (o_VALID=1, i_READY=0): o_VALID and o_Y hold unchanged, whatever the value of i_EN. An item is never withdrawn.
  - DONE: o_VALID=0, o_DONE=1. Left only by reset.
- Payload:
  - MODE 0: o_Y = lfsr[WIDTH-1:0], sampled from the post-step LFSR.
  - MODE 1: o_Y = data counter. The counter increments on each transfer and wraps modulo 2^WIDTH, so the sequence is 0,1,…,2^WIDTH-1,0.
- On each transfer, o_CNT increments.
- If N_ITEMS>0 and the transfer is item N_ITEMS-1: next state DONE, o_VALID=0, o_DONE=1 on the same edge.
- o_LAST = o_VALID & (o_CNT == N_ITEMS-1) when N_ITEMS>0; otherwise 0.
- DENSITY=16: valid is launched every free slot. DENSITY=0: valid is never launched and the state stays ACTIVE.
- Simultaneous transfer and launch on one edge gives a back-to-back item, with no bubble.

## Timing
- All outputs are registered. There is no combinational path from i_READY or i_EN to any output, and no # delays.
- Start-up latency:
  - i_EN sampled high at edge k → ACTIVE after edge k.
  - Earliest o_VALID=1 is after edge k+1.
- Throughput: one item per cycle when DENSITY=16 and i_READY=1.
- Reset mid-stall: outputs clear immediately on i_RSTn fall. After release, the same sequence replays from SEED.
- o_DONE rises on the same edge that accepts the final item.

## Structure
- Package stream_src_pkg holds:
  - the state enum: IDLE, ACTIVE, DONE;
  - the LFSR tap constant 32'h8020_0003;
  - the MODE constants: MODE_RANDOM=0, MODE_INCR=1.
- One sub-module, lfsr32: ports for step enable and synchronous load of the seed, async reset to seed, 32-bit state out.
- The top level holds the FSM, the payload register, the data counter and the transfer counter.

## Test plan
- Reset/idle: i_RSTn low, then release with i_EN=0 for 10 cycles → all outputs 0 throughout.
- MODE=1, DENSITY=16, i_READY=1, i_EN=1, WIDTH=9:
  - o_VALID rises 2 edges after i_EN.
  - o_Y runs 0..511 then 0 (wrap).
  - o_CNT increments every cycle.
- Backpressure, MODE=0, DENSITY=16: hold i_READY=0 for 5 cycles while o_VALID=1, and drop i_EN during the stall.
  - o_Y and o_VALID are unchanged and o_CNT is frozen.
  - Payloads match a reference Galois model seeded with 100.
- N_ITEMS=4, MODE=1: o_Y=3 is presented with o_LAST=1. After its transfer: o_DONE=1, o_VALID=0 permanently, o_CNT=4.
- Density:
  - DENSITY=0 over 1000 cycles → no valid.
  - DENSITY=8 with i_READY=1 over 10000 cycles → valid duty 40–60 %.
- Reset mid-stall: i_RSTn falls while o_VALID=1 and i_READY=0.
  - Outputs are 0 asynchronously.
  - After release, the first 8 items equal the first 8 items of the initial run.
